// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, state type and width decode for the servo PWM path
package pwm_pkg;

   localparam int PERIOD_NOM = 2000;

   // Width set driven by the servo generator, in 100 kHz ticks.
   localparam int W_01 = 130;
   localparam int W_00 = 153;
   localparam int W_10 = 170;

   localparam int DEC_LO_MAX  = 141;
   localparam int DEC_MID_MAX = 161;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   function automatic logic [1:0] decode_sw(input int unsigned width);
      if (width <= DEC_LO_MAX)
         return 2'b01;
      else if (width <= DEC_MID_MAX)
         return 2'b00;
      else
         return 2'b10;
   endfunction

endpackage

// File: rtl/pwm_in_filter.sv
// rtl/pwm_in_filter.sv - input synchroniser, glitch filter and edge detect for pwm_in
module pwm_in_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 2
) (
   input  logic clk_100KHz,
   input  logic reset_n,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [FW-1:0]          run_cnt;
   logic                   level_d;
   logic                   sync_out;

   assign sync_out = sync[SYNC_STAGES-1];

   always_ff @(posedge clk_100KHz or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      end
   end

   // run_cnt counts consecutive samples that disagree with the filtered level.
   always_ff @(posedge clk_100KHz or negedge reset_n) begin
      if (!reset_n) begin
         run_cnt <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         level_d <= level;
         if (sync_out == level) begin
            run_cnt <= '0;
         end else if (run_cnt == FW'(FILTER_LEN - 1)) begin
            run_cnt <= '0;
            level   <= sync_out;
         end else begin
            run_cnt <= run_cnt + FW'(1);
         end
      end
   end

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures width and period of an incoming PWM/servo pulse train
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 2,
   parameter int TIMEOUT     = 4000,
   parameter int WIDTH_MIN   = 50,
   parameter int WIDTH_MAX   = 250
) (
   input  logic                 clk_100KHz,
   input  logic                 reset_n,
   input  logic                 pwm_in,
   output logic [CNT_WIDTH-1:0] width_out,
   output logic [CNT_WIDTH-1:0] period_out,
   output logic                 meas_valid,
   output logic [1:0]           sw_code,
   output logic                 range_err,
   output logic                 signal_lost
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TO_LIMIT  = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] W_LO      = CNT_WIDTH'(WIDTH_MIN);
   localparam logic [CNT_WIDTH-1:0] W_HI      = CNT_WIDTH'(WIDTH_MAX);

   logic                 level;
   logic                 rise;
   logic                 fall;
   logic                 edge_any;
   logic                 timeout_hit;
   state_t               state;
   logic [CNT_WIDTH-1:0] hi_cnt;
   logic [CNT_WIDTH-1:0] per_cnt;
   logic [CNT_WIDTH-1:0] idle_cnt;
   logic [CNT_WIDTH-1:0] hi_inc;
   logic [CNT_WIDTH-1:0] per_inc;

   pwm_in_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk_100KHz(clk_100KHz),
      .reset_n   (reset_n),
      .pwm_in    (pwm_in),
      .level     (level),
      .rise      (rise),
      .fall      (fall)
   );

   assign edge_any = rise | fall;
   // An edge in the same tick as expiry keeps the signal alive.
   assign timeout_hit = !edge_any && (idle_cnt == TO_LIMIT - CNT_ONE);

   assign hi_inc  = (hi_cnt  == CNT_MAX) ? hi_cnt  : hi_cnt  + CNT_ONE;
   assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;

   always_ff @(posedge clk_100KHz or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         hi_cnt      <= '0;
         per_cnt     <= '0;
         idle_cnt    <= '0;
         width_out   <= '0;
         period_out  <= '0;
         meas_valid  <= 1'b0;
         sw_code     <= 2'b00;
         range_err   <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         meas_valid <= 1'b0;

         if (edge_any)
            idle_cnt <= '0;
         else if (idle_cnt != TO_LIMIT)
            idle_cnt <= idle_cnt + CNT_ONE;

         if (timeout_hit) begin
            signal_lost <= 1'b1;
            state       <= IDLE;
            hi_cnt      <= '0;
            per_cnt     <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (rise) begin
                     hi_cnt  <= CNT_ONE;
                     per_cnt <= CNT_ONE;
                     state   <= HIGH;
                  end
               end
               HIGH: begin
                  per_cnt <= per_inc;
                  if (!level)
                     state <= LOW;
                  else
                     hi_cnt <= hi_inc;
               end
               LOW: begin
                  if (rise) begin
                     width_out   <= hi_cnt;
                     period_out  <= per_cnt;
                     meas_valid  <= 1'b1;
                     sw_code     <= decode_sw(32'(hi_cnt));
                     range_err   <= (hi_cnt < W_LO) || (hi_cnt > W_HI);
                     signal_lost <= 1'b0;
                     hi_cnt      <= CNT_ONE;
                     per_cnt     <= CNT_ONE;
                     state       <= HIGH;
                  end else begin
                     per_cnt <= per_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

   localparam int CW  = 16;
   localparam int TO  = 4000;
   localparam int LAT = 5;

   logic          clk_100KHz = 1'b0;
   logic          reset_n    = 1'b0;
   logic          pwm_in     = 1'b0;
   logic [CW-1:0] width_out;
   logic [CW-1:0] period_out;
   logic          meas_valid;
   logic [1:0]    sw_code;
   logic          range_err;
   logic          signal_lost;

   pwm_capture #(
      .CNT_WIDTH  (CW),
      .SYNC_STAGES(2),
      .FILTER_LEN (2),
      .TIMEOUT    (TO),
      .WIDTH_MIN  (50),
      .WIDTH_MAX  (250)
   ) dut (
      .clk_100KHz (clk_100KHz),
      .reset_n    (reset_n),
      .pwm_in     (pwm_in),
      .width_out  (width_out),
      .period_out (period_out),
      .meas_valid (meas_valid),
      .sw_code    (sw_code),
      .range_err  (range_err),
      .signal_lost(signal_lost)
   );

   always #5 clk_100KHz = ~clk_100KHz;

   int cyc = 0;
   always @(posedge clk_100KHz) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         due;
      int         w;
      int         p;
      logic [1:0] sw;
      logic       rerr;
   } exp_t;

   typedef struct {
      int         hi;
      int         per;
      bit         gl;
      logic [1:0] sw;
      logic       rerr;
   } vec_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t tbl[14];

   logic       pend_v = 1'b0;
   int         pend_w, pend_p;
   logic [1:0] pend_sw;
   logic       pend_rerr;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk_100KHz) begin
      if (reset_n && meas_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_meas_valid", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            check("meas_cycle", cyc, mon_e.due);
            check("width_out", int'(width_out), mon_e.w);
            check("period_out", int'(period_out), mon_e.p);
            check("sw_code", int'(sw_code), int'(mon_e.sw));
            check("range_err", int'(range_err), int'(mon_e.rerr));
            check("signal_lost_on_meas", int'(signal_lost), 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_100KHz);
   endtask

   // Drive a rise; the measurement of the previous frame is due LAT ticks later.
   task automatic drive_rise();
      exp_t e;
      pwm_in = 1'b1;
      if (pend_v) begin
         e.due  = cyc + LAT;
         e.w    = pend_w;
         e.p    = pend_p;
         e.sw   = pend_sw;
         e.rerr = pend_rerr;
         sbq.push_back(e);
      end
   endtask

   task automatic frame(input vec_t v);
      int lo;
      drive_rise();
      pend_v    = 1'b1;
      pend_w    = v.hi;
      pend_p    = v.per;
      pend_sw   = v.sw;
      pend_rerr = v.rerr;
      lo = v.per - v.hi;
      if (v.gl) begin
         tick(v.hi / 2);
         pwm_in = 1'b0;
         tick(1);
         pwm_in = 1'b1;
         tick(v.hi - v.hi / 2 - 1);
         pwm_in = 1'b0;
         tick(lo / 2);
         pwm_in = 1'b1;
         tick(1);
         pwm_in = 1'b0;
         tick(lo - lo / 2 - 1);
      end else begin
         tick(v.hi);
         pwm_in = 1'b0;
         tick(lo);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_width"}, int'(width_out), 0);
      check({tag, "_period"}, int'(period_out), 0);
      check({tag, "_meas_valid"}, int'(meas_valid), 0);
      check({tag, "_sw_code"}, int'(sw_code), 0);
      check({tag, "_range_err"}, int'(range_err), 0);
      check({tag, "_signal_lost"}, int'(signal_lost), 1);
   endtask

   initial begin
      vec_t nom;
      int   f;
      int   k;

      tbl[0]  = '{153, 2000, 1'b0, 2'b00, 1'b0};
      tbl[1]  = '{153, 2000, 1'b0, 2'b00, 1'b0};
      tbl[2]  = '{130, 2000, 1'b0, 2'b01, 1'b0};
      tbl[3]  = '{170, 2000, 1'b0, 2'b10, 1'b0};
      tbl[4]  = '{153, 2000, 1'b1, 2'b00, 1'b0};
      tbl[5]  = '{20,  2000, 1'b0, 2'b01, 1'b1};
      tbl[6]  = '{141, 400,  1'b0, 2'b01, 1'b0};
      tbl[7]  = '{142, 400,  1'b0, 2'b00, 1'b0};
      tbl[8]  = '{161, 400,  1'b0, 2'b00, 1'b0};
      tbl[9]  = '{162, 400,  1'b0, 2'b10, 1'b0};
      tbl[10] = '{49,  400,  1'b0, 2'b01, 1'b1};
      tbl[11] = '{50,  400,  1'b0, 2'b01, 1'b0};
      tbl[12] = '{250, 400,  1'b0, 2'b10, 1'b0};
      tbl[13] = '{251, 400,  1'b0, 2'b10, 1'b1};
      nom     = '{153, 2000, 1'b0, 2'b00, 1'b0};

      tick(3);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      tick(5);

      for (int i = 0; i < 14; i++) frame(tbl[i]);

      // Close the last table frame, then hold low until loss of signal.
      drive_rise();
      pend_v = 1'b0;
      tick(153);
      pwm_in = 1'b0;
      f = cyc;
      check("lost_before_timeout", int'(signal_lost), 0);
      k = 0;
      while (k < TO + 50 && !signal_lost) begin
         tick(1);
         k++;
      end
      check("timeout_cycles", cyc - f, TO + LAT);
      tick(20);

      frame(nom);
      check("lost_after_first_rise", int'(signal_lost), 1);
      frame(nom);

      // Reset in the middle of a HIGH phase.
      drive_rise();
      pend_v = 1'b0;
      tick(70);
      pwm_in  = 1'b0;
      reset_n = 1'b0;
      tick(1);
      check_reset_outputs("midreset");
      tick(2);
      reset_n = 1'b1;
      tick(50);
      check_reset_outputs("postreset");
      frame(nom);
      frame(nom);
      drive_rise();
      tick(20);
      pwm_in = 1'b0;

      k = 0;
      while (k < 100 && sbq.size() != 0) begin
         tick(1);
         k++;
      end
      check("scoreboard_drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
